// File: rtl/spawn_scheduler.sv
// Spawn scheduler: draws a frame delay and slot preference from the prbs word,
// counts frames down, picks a free enemy slot and issues a held one-hot request.
module spawn_scheduler #(
  parameter int unsigned SPAWN_COUNTER_SIZE = 6,
  parameter int unsigned NBR_ENEMIES        = 8
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      frame_tick,
  input  logic [SPAWN_COUNTER_SIZE+NBR_ENEMIES-1:0] prbs_val,
  input  logic [NBR_ENEMIES-1:0]                    enemy_alive,
  input  logic                                      game_run,
  input  logic                                      spawn_ack,
  output logic                                      spawn_req,
  output logic [NBR_ENEMIES-1:0]                    spawn_slot,
  output logic [SPAWN_COUNTER_SIZE-1:0]             countdown,
  output logic [7:0]                                spawn_count
);

  localparam int unsigned CW = SPAWN_COUNTER_SIZE;
  localparam int unsigned NE = NBR_ENEMIES;

  typedef enum logic [1:0] {
    S_ARM    = 2'd0,
    S_COUNT  = 2'd1,
    S_SELECT = 2'd2,
    S_REQ    = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   countdown_q, countdown_d;
  logic [NE-1:0]   mask_q, mask_d;
  logic            spawn_req_q, spawn_req_d;
  logic [NE-1:0]   spawn_slot_q, spawn_slot_d;
  logic [7:0]      spawn_count_q, spawn_count_d;

  logic [CW-1:0]   delay_c;
  logic [NE-1:0]   free_c, vacant_c, pick_c;

  assign delay_c  = prbs_val[CW-1:0];
  assign free_c   = mask_q & ~enemy_alive;
  assign vacant_c = ~enemy_alive;

  // Lowest preferred free slot, else lowest free slot at all; zero when full.
  always_comb begin
    pick_c = '0;
    if (free_c != '0) begin
      pick_c = free_c & (~free_c + NE'(1));
    end else begin
      pick_c = vacant_c & (~vacant_c + NE'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_ARM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!game_run) begin
      state_d = S_ARM;
    end else begin
      unique case (state_q)
        S_ARM:    if (frame_tick) state_d = S_COUNT;
        S_COUNT:  if (frame_tick && countdown_q == CW'(1)) state_d = S_SELECT;
        S_SELECT: state_d = (pick_c != '0) ? S_REQ : S_ARM;
        S_REQ:    if (spawn_ack) state_d = S_ARM;
        default:  state_d = S_ARM;
      endcase
    end
  end

  // Next values of the registered outputs and the latched mask.
  always_comb begin
    countdown_d   = countdown_q;
    mask_d        = mask_q;
    spawn_req_d   = spawn_req_q;
    spawn_slot_d  = spawn_slot_q;
    spawn_count_d = spawn_count_q;
    if (!game_run) begin
      countdown_d  = '0;
      spawn_req_d  = 1'b0;
      spawn_slot_d = '0;
    end else begin
      unique case (state_q)
        S_ARM: begin
          if (frame_tick) begin
            countdown_d = (delay_c == '0) ? CW'(1) : delay_c;
            mask_d      = prbs_val[CW+NE-1:CW];
          end
        end
        S_COUNT: begin
          if (frame_tick) countdown_d = countdown_q - CW'(1);
        end
        S_SELECT: begin
          if (pick_c != '0) begin
            spawn_req_d  = 1'b1;
            spawn_slot_d = pick_c;
          end
        end
        S_REQ: begin
          if (spawn_ack) begin
            spawn_req_d   = 1'b0;
            spawn_slot_d  = '0;
            spawn_count_d = spawn_count_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      countdown_q   <= '0;
      mask_q        <= '0;
      spawn_req_q   <= 1'b0;
      spawn_slot_q  <= '0;
      spawn_count_q <= '0;
    end else begin
      countdown_q   <= countdown_d;
      mask_q        <= mask_d;
      spawn_req_q   <= spawn_req_d;
      spawn_slot_q  <= spawn_slot_d;
      spawn_count_q <= spawn_count_d;
    end
  end

  assign spawn_req   = spawn_req_q;
  assign spawn_slot  = spawn_slot_q;
  assign countdown   = countdown_q;
  assign spawn_count = spawn_count_q;

endmodule

// File: tb/tb_spawn_scheduler.sv
// Directed testbench for spawn_scheduler: load/count/select/request/ack flows,
// slot choice, zero delay, abort, hold, async reset and counter wrap.
module tb_spawn_scheduler;

  logic        clk;
  logic        rst_n;
  logic        frame_tick;
  logic [13:0] prbs_val;
  logic [7:0]  enemy_alive;
  logic        game_run;
  logic        spawn_ack;
  logic        spawn_req;
  logic [7:0]  spawn_slot;
  logic [5:0]  countdown;
  logic [7:0]  spawn_count;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  exp_count = 8'd0;

  spawn_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .prbs_val    (prbs_val),
    .enemy_alive (enemy_alive),
    .game_run    (game_run),
    .spawn_ack   (spawn_ack),
    .spawn_req   (spawn_req),
    .spawn_slot  (spawn_slot),
    .countdown   (countdown),
    .spawn_count (spawn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  // Load M/D, count the frames down, then check the SELECT outcome.
  task automatic do_spawn(input string tag, input logic [7:0] m, input logic [5:0] d,
                          input logic [7:0] alive, input logic [7:0] exp_slot);
    int deff;
    deff = (d == 6'd0) ? 1 : int'(d);
    enemy_alive = alive;
    prbs_val = {m, d};
    tick();
    check_eq({tag, "_load_cd"}, 32'(countdown), 32'(deff));
    prbs_val = ~{m, d};
    for (int i = 0; i < deff; i++) begin
      tick();
      check_eq({tag, "_cd"}, 32'(countdown), 32'(deff - 1 - i));
    end
    check_eq({tag, "_sel_req"}, 32'(spawn_req), 32'd0);
    step();
    check_eq({tag, "_req"}, 32'(spawn_req), 32'(exp_slot != 8'd0));
    check_eq({tag, "_slot"}, 32'(spawn_slot), 32'(exp_slot));
  endtask

  task automatic do_ack(input string tag);
    spawn_ack = 1'b1;
    step();
    spawn_ack = 1'b0;
    exp_count = exp_count + 8'd1;
    check_eq({tag, "_ack_req"}, 32'(spawn_req), 32'd0);
    check_eq({tag, "_ack_slot"}, 32'(spawn_slot), 32'd0);
    check_eq({tag, "_ack_cnt"}, 32'(spawn_count), 32'(exp_count));
  endtask

  initial begin
    rst_n = 1'b0;
    frame_tick = 1'b0;
    prbs_val = '0;
    enemy_alive = '0;
    game_run = 1'b0;
    spawn_ack = 1'b0;
    #23;
    check_eq("rst_req", 32'(spawn_req), 32'd0);
    check_eq("rst_slot", 32'(spawn_slot), 32'd0);
    check_eq("rst_cd", 32'(countdown), 32'd0);
    check_eq("rst_cnt", 32'(spawn_count), 32'd0);
    rst_n = 1'b1;
    step();
    game_run = 1'b1;

    do_spawn("basic", 8'h03, 6'd3, 8'h00, 8'h01);
    do_ack("basic");
    do_spawn("pref2", 8'h03, 6'd3, 8'h01, 8'h02);
    do_ack("pref2");
    do_spawn("fallback", 8'h00, 6'd2, 8'h0F, 8'h10);
    do_ack("fallback");

    do_spawn("full", 8'hAA, 6'd1, 8'hFF, 8'h00);
    step();
    check_eq("full_req", 32'(spawn_req), 32'd0);
    check_eq("full_cnt", 32'(spawn_count), 32'(exp_count));

    do_spawn("zero_d", 8'h04, 6'd0, 8'h00, 8'h04);
    do_ack("zero_d");

    // Request held across ignored ticks and an enemy_alive change.
    do_spawn("hold", 8'h20, 6'd2, 8'h00, 8'h20);
    enemy_alive = 8'h20;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("hold_req", 32'(spawn_req), 32'd1);
      check_eq("hold_slot", 32'(spawn_slot), 32'h20);
      check_eq("hold_cd", 32'(countdown), 32'd0);
    end
    enemy_alive = 8'h00;
    do_ack("hold");

    // Abort wins over a simultaneous ack.
    do_spawn("abort", 8'h01, 6'd1, 8'h00, 8'h01);
    game_run = 1'b0;
    spawn_ack = 1'b1;
    step();
    spawn_ack = 1'b0;
    check_eq("abort_req", 32'(spawn_req), 32'd0);
    check_eq("abort_slot", 32'(spawn_slot), 32'd0);
    check_eq("abort_cd", 32'(countdown), 32'd0);
    check_eq("abort_cnt", 32'(spawn_count), 32'(exp_count));
    game_run = 1'b1;
    do_spawn("post_abort", 8'h02, 6'd1, 8'h00, 8'h02);
    do_ack("post_abort");

    // Asynchronous reset mid-COUNT.
    prbs_val = {8'h01, 6'd5};
    tick();
    check_eq("mid_cd", 32'(countdown), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_req", 32'(spawn_req), 32'd0);
    check_eq("async_slot", 32'(spawn_slot), 32'd0);
    check_eq("async_cd", 32'(countdown), 32'd0);
    check_eq("async_cnt", 32'(spawn_count), 32'd0);
    #2 rst_n = 1'b1;
    exp_count = 8'd0;
    for (int i = 0; i < 3; i++) step();
    check_eq("post_rst_req", 32'(spawn_req), 32'd0);
    check_eq("post_rst_cd", 32'(countdown), 32'd0);

    // 256 accepted spawns wrap the counter back to zero.
    prbs_val = {8'h01, 6'd1};
    enemy_alive = 8'h00;
    for (int i = 0; i < 256; i++) begin
      tick();
      tick();
      step();
      spawn_ack = 1'b1;
      step();
      spawn_ack = 1'b0;
      exp_count = exp_count + 8'd1;
      if (i == 254) check_eq("cnt_255", 32'(spawn_count), 32'd255);
    end
    check_eq("wrap_cnt", 32'(spawn_count), 32'(exp_count));
    check_eq("wrap_zero", 32'(spawn_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
